// File: rtl/phase_shift_filter_if.sv
// Handshake-free control bundle between the DPLL reference/divider side and
// phase_shift_filter: conditioning inputs, shift pulses and lock status.
// Ports (slave = filter side):
//   in  enable_i, ref_i, fb_i, k_limit_i[K_WIDTH]
//   out positiveShift_o, negativeShift_o, lock_o
//   out phaseErr_o[ERR_WIDTH+1], phaseErrValid_o (only with PHASE_SHIFT_ERR_OUT_EN)
interface phase_shift_filter_if #(
    parameter int K_WIDTH = 6
`ifdef PHASE_SHIFT_ERR_OUT_EN
    , parameter int ERR_WIDTH = 8
`endif
);
    logic               enable_i;
    logic               ref_i;
    logic               fb_i;
    logic [K_WIDTH-1:0] k_limit_i;
    logic               positiveShift_o;
    logic               negativeShift_o;
    logic               lock_o;
`ifdef PHASE_SHIFT_ERR_OUT_EN
    logic signed [ERR_WIDTH:0] phaseErr_o;
    logic                      phaseErrValid_o;
`endif

    modport master (
        output enable_i, ref_i, fb_i, k_limit_i,
        input  positiveShift_o, negativeShift_o, lock_o
`ifdef PHASE_SHIFT_ERR_OUT_EN
        , input phaseErr_o, phaseErrValid_o
`endif
    );

    modport slave (
        input  enable_i, ref_i, fb_i, k_limit_i,
        output positiveShift_o, negativeShift_o, lock_o
`ifdef PHASE_SHIFT_ERR_OUT_EN
        , output phaseErr_o, phaseErrValid_o
`endif
    );
endinterface

// File: rtl/phase_shift_filter.sv
// DPLL phase detector + random-walk (K-counter) filter producing one-cycle
// advance/retard pulses for the divider, plus lock detection.
// Ports: clk_i, reset_i (async, active-high), bus (phase_shift_filter_if.slave).
// Optional macro PHASE_SHIFT_ERR_OUT_EN adds phaseErr_o/phaseErrValid_o.
module phase_shift_filter #(
    parameter int K_WIDTH    = 6,
    parameter int ERR_WIDTH  = 8,
    parameter int DEADBAND   = 1,
    parameter int HOLDOFF    = 4,
    parameter int LOCK_COUNT = 8
) (
    input  logic                clk_i,
    input  logic                reset_i,
    phase_shift_filter_if.slave bus
);
    localparam int CW = K_WIDTH + 1;
    localparam int HW = $clog2(HOLDOFF + 2);
    localparam int LW = $clog2(LOCK_COUNT + 2);

    localparam logic [1:0] IDLE     = 2'd0;
    localparam logic [1:0] WAIT_FB  = 2'd1;
    localparam logic [1:0] WAIT_REF = 2'd2;

    localparam logic [ERR_WIDTH-1:0] ERR_MAX = '1;
    localparam logic [ERR_WIDTH-1:0] ERR_ONE = ERR_WIDTH'(1);
    localparam logic [ERR_WIDTH-1:0] DB      = ERR_WIDTH'(DEADBAND);
    localparam logic [HW-1:0]        HO_LOAD = HW'(HOLDOFF);
    localparam logic [LW-1:0]        LK_MAX  = LW'(LOCK_COUNT);
    localparam logic signed [CW-1:0] C_ONE   = CW'(1);

    logic ref_s1, ref_s2, ref_d, fb_d;
    logic ref_rise, fb_rise;

    logic [1:0]           state_q, state_d;
    logic [ERR_WIDTH-1:0] err_q, err_d;
    logic                 meas_vld, meas_lag, abort;
    logic [ERR_WIDTH-1:0] meas_err;

    logic signed [CW-1:0] c_q, c_cl, k_top;
    logic [K_WIDTH-1:0]   k_lim;
    logic [HW-1:0]        ho_q;
    logic [LW-1:0]        streak_q, streak_inc;
    logic                 pos_q, neg_q, lock_q;
    logic                 meas_use, vote_ok;

    assign ref_rise = ref_s2 & ~ref_d;
    assign fb_rise  = bus.fb_i & ~fb_d;

    // Phase detector: measures the distance between paired edges.
    always_comb begin
        state_d  = state_q;
        err_d    = err_q;
        meas_vld = 1'b0;
        meas_lag = 1'b0;
        meas_err = '0;
        abort    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (ref_rise && fb_rise) begin
                    meas_vld = 1'b1;
                end else if (ref_rise) begin
                    err_d   = ERR_ONE;
                    state_d = WAIT_FB;
                end else if (fb_rise) begin
                    err_d   = ERR_ONE;
                    state_d = WAIT_REF;
                end
            end
            WAIT_FB: begin
                if (fb_rise || ref_rise) begin
                    meas_vld = 1'b1;
                    meas_lag = 1'b1;
                    meas_err = err_q;
                    // a fresh ref edge opens the next measurement at once
                    if (ref_rise) err_d = ERR_ONE;
                    else          state_d = IDLE;
                end else if (err_q == ERR_MAX) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d = err_q + ERR_ONE;
                end
            end
            WAIT_REF: begin
                if (ref_rise || fb_rise) begin
                    meas_vld = 1'b1;
                    meas_err = err_q;
                    if (fb_rise) err_d = ERR_ONE;
                    else         state_d = IDLE;
                end else if (err_q == ERR_MAX) begin
                    abort   = 1'b1;
                    state_d = IDLE;
                end else begin
                    err_d = err_q + ERR_ONE;
                end
            end
            default: begin
                state_d = IDLE;
                err_d   = '0;
            end
        endcase
    end

    // k_limit_i may shrink under a live counter; clamp before use.
    always_comb begin
        k_lim = (bus.k_limit_i == '0) ? K_WIDTH'(1) : bus.k_limit_i;
        k_top = $signed({1'b0, k_lim - K_WIDTH'(1)});
        if (c_q > k_top)       c_cl = k_top;
        else if (c_q < -k_top) c_cl = -k_top;
        else                   c_cl = c_q;
    end

    assign meas_use   = bus.enable_i & meas_vld;
    assign vote_ok    = meas_use & (meas_err > DB) & (ho_q == '0);
    assign streak_inc = (streak_q == LK_MAX) ? streak_q : streak_q + LW'(1);

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            ref_s1   <= 1'b0;
            ref_s2   <= 1'b0;
            ref_d    <= 1'b0;
            fb_d     <= 1'b0;
            state_q  <= IDLE;
            err_q    <= '0;
            c_q      <= '0;
            ho_q     <= '0;
            streak_q <= '0;
            pos_q    <= 1'b0;
            neg_q    <= 1'b0;
            lock_q   <= 1'b0;
        end else begin
            ref_s1 <= bus.ref_i;
            ref_s2 <= ref_s1;
            ref_d  <= ref_s2;
            fb_d   <= bus.fb_i;
            pos_q  <= 1'b0;
            neg_q  <= 1'b0;
            if (!bus.enable_i) begin
                state_q  <= IDLE;
                err_q    <= '0;
                ho_q     <= '0;
                streak_q <= '0;
                lock_q   <= 1'b0;
            end else begin
                state_q <= state_d;
                err_q   <= err_d;
                if (ho_q != '0) ho_q <= ho_q - HW'(1);
                if (vote_ok) begin
                    if (meas_lag) begin
                        if (c_cl == k_top) begin
                            pos_q <= 1'b1;
                            c_q   <= '0;
                            ho_q  <= HO_LOAD;
                        end else begin
                            c_q <= c_cl + C_ONE;
                        end
                    end else begin
                        if (c_cl == -k_top) begin
                            neg_q <= 1'b1;
                            c_q   <= '0;
                            ho_q  <= HO_LOAD;
                        end else begin
                            c_q <= c_cl - C_ONE;
                        end
                    end
                end
                if (abort) begin
                    streak_q <= '0;
                    lock_q   <= 1'b0;
                end else if (meas_vld) begin
                    if (meas_err <= DB) begin
                        streak_q <= streak_inc;
                        if (streak_inc >= LK_MAX) lock_q <= 1'b1;
                    end else begin
                        streak_q <= '0;
                        lock_q   <= 1'b0;
                    end
                end
            end
        end
    end

    assign bus.positiveShift_o = pos_q;
    assign bus.negativeShift_o = neg_q;
    assign bus.lock_o          = lock_q;

`ifdef PHASE_SHIFT_ERR_OUT_EN
    logic signed [ERR_WIDTH:0] pe_q;
    logic                      pe_vld_q;

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            pe_q     <= '0;
            pe_vld_q <= 1'b0;
        end else begin
            pe_vld_q <= meas_use;
            if (meas_use) begin
                pe_q <= meas_lag ? $signed({1'b0, meas_err})
                                 : -$signed({1'b0, meas_err});
            end
        end
    end

    assign bus.phaseErr_o      = pe_q;
    assign bus.phaseErrValid_o = pe_vld_q;
`endif
endmodule

// File: tb/tb_phase_shift_filter.sv
// Scoreboard bench for phase_shift_filter: expected pulses / errors queued
// at stimulus time, popped and compared when the DUT emits them.
module tb_phase_shift_filter;
    typedef struct {
        int cyc;
        int val;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   checks = 0;
    int   failures = 0;
    exp_t pulse_q[$];
    exp_t err_q[$];
    exp_t mon_e;
    int   dl[8] = '{0, 1, -1, 0, 1, 0, -1, 1};

`ifdef PHASE_SHIFT_ERR_OUT_EN
    phase_shift_filter_if #(.K_WIDTH(6), .ERR_WIDTH(8)) bus ();
`else
    phase_shift_filter_if #(.K_WIDTH(6)) bus ();
`endif

    phase_shift_filter dut (
        .clk_i  (clk),
        .reset_i(rst),
        .bus    (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        if (obs != exp) begin
            failures++;
            $display("FAIL %s: got %0d want %0d (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    // Output monitor: every pulse / valid must match the queued head.
    always @(negedge clk) begin
        if (!rst) begin
            if (bus.positiveShift_o || bus.negativeShift_o) begin
                check("both_pulses",
                      int'(bus.positiveShift_o & bus.negativeShift_o), 0);
                if (pulse_q.size() == 0) begin
                    check("unexpected_pulse", 1, 0);
                end else begin
                    mon_e = pulse_q.pop_front();
                    check("pulse_cyc", cyc, mon_e.cyc);
                    check("pulse_kind", bus.positiveShift_o ? 1 : 2, mon_e.val);
                end
            end
`ifdef PHASE_SHIFT_ERR_OUT_EN
            if (bus.phaseErrValid_o) begin
                if (err_q.size() == 0) begin
                    check("unexpected_err_valid", 1, 0);
                end else begin
                    mon_e = err_q.pop_front();
                    check("err_cyc", cyc, mon_e.cyc);
                    check("err_val", int'(bus.phaseErr_o), mon_e.val);
                end
            end
`endif
        end
    end

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    // One ref/fb pair: fb strobe lands l cycles after the ref strobe.
    // want: 0 none, 1 positive, 2 negative. lk_*: -1 skips the lock check.
    task automatic period(input int l, input int want,
                          input int lk_pre, input int lk_post);
        int r, f, b, close, span;
        r     = (l + 2 < 0) ? -(l + 2) : 0;
        f     = r + 2 + l;
        b     = cyc;
        close = b + (((r + 2) > f) ? (r + 2) : f);
        span  = ((r > f) ? r : f) + 8;
        if (want != 0) pulse_q.push_back('{close + 1, want});
        if (bus.enable_i) err_q.push_back('{close + 1, l});
        for (int i = 0; i < span; i++) begin
            bus.ref_i = (i >= r && i < r + 4);
            bus.fb_i  = (i >= f && i < f + 4);
            if (cyc == close && lk_pre >= 0)
                check("lock_pre", int'(bus.lock_o), lk_pre);
            if (cyc == close + 1 && lk_post >= 0)
                check("lock_post", int'(bus.lock_o), lk_post);
            @(negedge clk);
        end
    endtask

    task automatic lock_up(input int l);
        for (int i = 0; i < 8; i++)
            period(l, 0, -1, (i == 6) ? 0 : ((i == 7) ? 1 : -1));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int b;
        bus.enable_i  = 1'b1;
        bus.ref_i     = 1'b0;
        bus.fb_i      = 1'b0;
        bus.k_limit_i = 6'd1;
        wait_n(3);
        check("rst_pos", int'(bus.positiveShift_o), 0);
        check("rst_neg", int'(bus.negativeShift_o), 0);
        check("rst_lock", int'(bus.lock_o), 0);
        rst = 1'b0;
        wait_n(3);

        // k=1: every out-of-deadband measurement shifts immediately
        period(3, 1, -1, 0);
        period(-6, 2, -1, 0);
        period(20, 1, -1, -1);

        // k=4: four leads per retard pulse, counter restarts at zero
        bus.k_limit_i = 6'd4;
        for (int i = 0; i < 8; i++)
            period(-5, (i == 3 || i == 7) ? 2 : 0, -1, 0);

        // in-deadband measurements build lock; one big error drops it
        for (int i = 0; i < 8; i++)
            period(dl[i], 0, -1, (i == 6) ? 0 : ((i == 7) ? 1 : -1));
        period(4, 0, 1, 0);

        // counter sits at +1; k=1 clamps it and shifts on the next lag
        bus.k_limit_i = 6'd0;
        period(2, 1, -1, 0);

        // holdoff: second lag two cycles after the first is discarded
        b = cyc;
        pulse_q.push_back('{b + 5, 1});
        err_q.push_back('{b + 5, 2});
        err_q.push_back('{b + 7, 2});
        for (int i = 0; i < 16; i++) begin
            bus.ref_i = (i == 0 || i == 2);
            bus.fb_i  = (i >= 6 && i < 9);
            @(negedge clk);
        end
        check("holdoff_pending", pulse_q.size(), 0);

        // missing feedback: counter saturates and FSM aborts silently
        for (int i = 0; i < 275; i++) begin
            bus.ref_i = (i < 4);
            @(negedge clk);
        end
        check("abort_lock", int'(bus.lock_o), 0);
        period(3, 1, -1, 0);

        // disable: lock drops, no pulses, no spurious edge on re-enable
        lock_up(0);
        bus.enable_i = 1'b0;
        wait_n(1);
        check("dis_lock", int'(bus.lock_o), 0);
        period(5, 0, -1, 0);
        bus.ref_i = 1'b1;
        wait_n(4);
        bus.enable_i = 1'b1;
        wait_n(4);
        bus.ref_i = 1'b0;
        wait_n(4);
        period(3, 1, -1, 0);

        // reset while waiting for feedback
        lock_up(1);
        for (int i = 0; i < 5; i++) begin
            bus.ref_i = (i < 2);
            @(negedge clk);
        end
        rst = 1'b1;
        #1;
        check("midrst_pos", int'(bus.positiveShift_o), 0);
        check("midrst_neg", int'(bus.negativeShift_o), 0);
        check("midrst_lock", int'(bus.lock_o), 0);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 12; i++) begin
            bus.fb_i = (i >= 1 && i < 5);
            @(negedge clk);
        end
        bus.enable_i = 1'b0;
        wait_n(2);
        bus.enable_i = 1'b1;
        wait_n(2);
        period(-3, 2, -1, 0);

        wait_n(5);
        check("pulse_pending", pulse_q.size(), 0);
`ifdef PHASE_SHIFT_ERR_OUT_EN
        check("err_pending", err_q.size(), 0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
